// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: latches a WIDTH-bit word on Start and
// shifts it out LSB-first on SOD, framed by SOV, with Busy/Done handshake.
module piso_shift_tx #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             Clk,
  input  logic             RS,
  input  logic             Start,
  input  logic [WIDTH-1:0] PD,
  output logic             SOD,
  output logic             SOV,
  output logic             Busy,
  output logic             Done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             sod_n, sov_n, busy_n, done_n;

  always_ff @(posedge Clk or posedge RS) begin
    if (RS) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      SOD   <= IDLE_LEVEL;
      SOV   <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
      SOD   <= sod_n;
      SOV   <= sov_n;
      Busy  <= busy_n;
      Done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (Start) begin
          sreg_n  = PD;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        sreg_n = sreg >> 1;
        // Counter holds on the last bit so it never wraps while shifting.
        if (cnt == LAST_BIT) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output flops are loaded from the next state so SOD carries PD[0] right after the accepting edge.
  always_comb begin
    sod_n  = IDLE_LEVEL;
    sov_n  = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    unique case (state_n)
      SHIFT: begin
        sod_n  = sreg_n[0];
        sov_n  = 1'b1;
        busy_n = 1'b1;
      end
      DONE: begin
        done_n = 1'b1;
        busy_n = 1'b1;
      end
      default: begin
        sod_n = IDLE_LEVEL;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: scoreboard of expected serial bits
// plus an 8-bit serial-in receiver fed from SOD for loopback.
module tb_piso_shift_tx;

  logic       Clk;
  logic       RS;
  logic       Start;
  logic [7:0] PD;
  logic       SOD;
  logic       SOV;
  logic       Busy;
  logic       Done;

  logic [7:0] rx_q;
  bit         exp_q[$];
  int         chk_cnt;
  int         pass_cnt;

  piso_shift_tx #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (
    .Clk  (Clk),
    .RS   (RS),
    .Start(Start),
    .PD   (PD),
    .SOD  (SOD),
    .SOV  (SOV),
    .Busy (Busy),
    .Done (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) rx_q <= {SOD, rx_q[7:1]};

  task automatic send(input logic [7:0] w);
    @(negedge Clk);
    PD    = w;
    Start = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic test_reset;
    bit b;
    chk_cnt++; if ({SOD, SOV, Busy, Done} !== 4'b0000) $display("FAIL reset_init: got %b want 0000", {SOD, SOV, Busy, Done}); else pass_cnt++;
    @(negedge Clk);
    RS = 1'b0;
    send(8'hFF);
    @(negedge Clk);
    @(negedge Clk);
    #2;
    RS = 1'b1;
    #1;
    chk_cnt++; if ({SOD, SOV, Busy, Done} !== 4'b0000) $display("FAIL reset_async: got %b want 0000", {SOD, SOV, Busy, Done}); else pass_cnt++;
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk_cnt++; if ({SOD, SOV, Busy, Done} !== 4'b0000) $display("FAIL reset_hold c%0d: got %b want 0000", c, {SOD, SOV, Busy, Done}); else pass_cnt++;
    end
    RS = 1'b0;
    @(negedge Clk);
    b = 1'b0;
    chk_cnt++; if (Busy !== b) $display("FAIL reset_release_busy: got %b want %b", Busy, b); else pass_cnt++;
  endtask

  task automatic test_single;
    bit e;
    send(8'hA5);
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      if (c <= 8) begin
        chk_cnt++; if (SOV !== 1'b1 || Busy !== 1'b1 || Done !== 1'b0) $display("FAIL single_ctl c%0d: got sov=%b busy=%b done=%b want 1 1 0", c, SOV, Busy, Done); else pass_cnt++;
        if (exp_q.size() == 0) begin
          chk_cnt++; $display("FAIL single_sb c%0d: got empty queue want bit", c);
        end else begin
          e = exp_q.pop_front();
          chk_cnt++; if (SOD !== e) $display("FAIL single_sod c%0d: got %b want %b", c, SOD, e); else pass_cnt++;
        end
      end else if (c == 9) begin
        chk_cnt++; if ({SOD, SOV, Busy, Done} !== 4'b0011) $display("FAIL single_done: got %b want 0011", {SOD, SOV, Busy, Done}); else pass_cnt++;
      end else begin
        chk_cnt++; if ({SOV, Busy, Done} !== 3'b000) $display("FAIL single_idle: got %b want 000", {SOV, Busy, Done}); else pass_cnt++;
      end
    end
  endtask

  task automatic test_loopback;
    bit e;
    send(8'h3C);
    for (int c = 1; c <= 9; c++) begin
      @(negedge Clk);
      if (SOV === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk_cnt++; $display("FAIL loop_sb c%0d: got empty queue want bit", c);
        end else begin
          e = exp_q.pop_front();
          chk_cnt++; if (SOD !== e) $display("FAIL loop_sod c%0d: got %b want %b", c, SOD, e); else pass_cnt++;
        end
      end
    end
    chk_cnt++; if (Done !== 1'b1) $display("FAIL loop_done: got %b want 1", Done); else pass_cnt++;
    chk_cnt++; if (rx_q !== 8'h3C) $display("FAIL loop_rx: got %h want 3c", rx_q); else pass_cnt++;
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL loop_left: got %0d bits left want 0", exp_q.size()); else pass_cnt++;
    @(negedge Clk);
  endtask

  task automatic test_back_to_back;
    bit e, exp_sov, exp_done;
    @(negedge Clk);
    PD    = 8'hFF;
    Start = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back(i == 0);
    @(posedge Clk);
    #1;
    PD = 8'h01;
    for (int c = 1; c <= 21; c++) begin
      @(negedge Clk);
      exp_sov  = (c <= 8) || (c >= 11 && c <= 18);
      exp_done = (c == 9) || (c == 19);
      chk_cnt++; if (SOV !== exp_sov) $display("FAIL b2b_sov c%0d: got %b want %b", c, SOV, exp_sov); else pass_cnt++;
      chk_cnt++; if (Done !== exp_done) $display("FAIL b2b_done c%0d: got %b want %b", c, Done, exp_done); else pass_cnt++;
      if (SOV === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk_cnt++; $display("FAIL b2b_sb c%0d: got empty queue want bit", c);
        end else begin
          e = exp_q.pop_front();
          chk_cnt++; if (SOD !== e) $display("FAIL b2b_sod c%0d: got %b want %b", c, SOD, e); else pass_cnt++;
        end
      end
      if (c == 11) begin
        Start = 1'b0;
        PD    = 8'h00;
      end
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL b2b_left: got %0d bits left want 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_ignored_start;
    bit e, exp_sov;
    send(8'h81);
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      exp_sov = (c <= 8);
      chk_cnt++; if (SOV !== exp_sov) $display("FAIL ign_sov c%0d: got %b want %b", c, SOV, exp_sov); else pass_cnt++;
      if (SOV === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk_cnt++; $display("FAIL ign_sb c%0d: got empty queue want bit", c);
        end else begin
          e = exp_q.pop_front();
          chk_cnt++; if (SOD !== e) $display("FAIL ign_sod c%0d: got %b want %b", c, SOD, e); else pass_cnt++;
        end
      end
      if (c == 3) begin
        PD    = 8'h00;
        Start = 1'b1;
      end else if (c == 4) begin
        Start = 1'b0;
      end
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL ign_left: got %0d bits left want 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_abort;
    bit e, exp_sov;
    send(8'h5A);
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clk);
      e = exp_q.pop_front();
      chk_cnt++; if (SOV !== 1'b1 || SOD !== e) $display("FAIL abort_pre c%0d: got sov=%b sod=%b want 1 %b", c, SOV, SOD, e); else pass_cnt++;
    end
    #2;
    RS = 1'b1;
    #1;
    chk_cnt++; if ({SOD, SOV, Busy, Done} !== 4'b0000) $display("FAIL abort_now: got %b want 0000", {SOD, SOV, Busy, Done}); else pass_cnt++;
    exp_q.delete();
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      chk_cnt++; if (Done !== 1'b0 || Busy !== 1'b0) $display("FAIL abort_hold c%0d: got done=%b busy=%b want 0 0", c, Done, Busy); else pass_cnt++;
    end
    // Release reset with Start already high: first edge after release accepts.
    RS    = 1'b0;
    PD    = 8'hC3;
    Start = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(PD[i]);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge Clk);
      exp_sov = (c <= 8);
      chk_cnt++; if (SOV !== exp_sov || Done !== (c == 9)) $display("FAIL abort_resend_ctl c%0d: got sov=%b done=%b want %b %b", c, SOV, Done, exp_sov, (c == 9)); else pass_cnt++;
      if (SOV === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk_cnt++; $display("FAIL abort_sb c%0d: got empty queue want bit", c);
        end else begin
          e = exp_q.pop_front();
          chk_cnt++; if (SOD !== e) $display("FAIL abort_sod c%0d: got %b want %b", c, SOD, e); else pass_cnt++;
        end
      end
      if (c == 9) begin
        chk_cnt++; if (rx_q !== 8'hC3) $display("FAIL abort_rx: got %h want c3", rx_q); else pass_cnt++;
      end
    end
    chk_cnt++; if (exp_q.size() != 0) $display("FAIL abort_left: got %0d bits left want 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    RS       = 1'b1;
    Start    = 1'b0;
    PD       = 8'h00;
    rx_q     = 8'h00;
    repeat (2) @(negedge Clk);
    test_reset();
    test_single();
    test_loopback();
    test_back_to_back();
    test_ignored_start();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
